ysyx_220053_cla_seq_ctrl: RTL and testbench
===========================================

Name: ysyx_220053_cla_seq_ctrl

Overview:
Multi-cycle adder/subtractor controller that time-shares one 8-bit carry-lookahead slice (ysyx_220053_CLA8) to add or subtract WIDTH-bit operands, one byte per cycle, low byte first.
- Sits beside the EXU as a low-area arithmetic unit for wide operands. Examples are 64-bit address or accumulator updates where latency is acceptable.
- Uses valid/ready handshakes on both input and output. Holds carry between slices and reports carry, signed overflow and zero flags.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of 8 and at least 8.
- NSLICE, WIDTH/8, derived number of byte slices; not overridable.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request.
- op_sub  input  1  0 = a+b, 1 = a-b (two's complement).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference.
- carry  output  1  final carry-out (for subtract, 1 = no borrow).
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n low, asynchronous):
  - state = IDLE; slice counter = 0; carry register = 0.
  - Operand and result registers = 0.
  - Outputs: in_ready=1, out_valid=0, result=0, carry=0, overflow=0, zero=0, busy=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready the edge does the following: latch a into opA; latch op_sub ? ~b : b into opB; carry register = op_sub; counter = 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, drive the slice with x=opA[8k+7:8k], y=opB[8k+7:8k], cin=carry register, where k = counter.
  - At the edge, store f into result[8k+7:8k], store cout into the carry register, and increment counter.
  - When k == NSLICE-1:
    - overflow = (sign bits of opA and opB equal) && (result MSB != opA MSB).
    - zero = (assembled result == 0).
    - carry output = cout.
    - Go to DONE.
- DONE:
  - out_valid=1; result and flags held stable.
  - On out_valid&&out_ready, return to IDLE.
  - No same-cycle acceptance of a new request in DONE: in_ready=0 until IDLE.
- Latency:
  - Acceptance edge T, then out_valid high from the cycle after edge T+NSLICE. For WIDTH=64 that is 8 RUN cycles.
  - Throughput: one operation per NSLICE+2 cycles when out_ready is held high.
- Output stability: result, carry, overflow and zero change only in RUN.
  - During RUN, result updates byte by byte and is not meaningful.
  - Flags are qualified only by out_valid.
- Backpressure: out_ready low in DONE holds all outputs indefinitely. Inputs are ignored.
- Simultaneous events: in_valid while not IDLE is ignored (no queuing). The requester must hold it until in_ready.
- Reset mid-RUN or mid-DONE: the operation is discarded; out_valid drops asynchronously; no result is ever presented.
- Counter width: clog2(NSLICE), minimum 1. Wrap is impossible because RUN exits at NSLICE-1.
- WIDTH=8: a single RUN cycle.

Decomposition:
- Shared package (ysyx_220053_pkg) holds:
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - SLICE_W=8.
- Exactly one sub-module: one ysyx_220053_CLA8 instance.
- Do not duplicate it per slice; the time-sharing is the point of the block.
- All remaining logic (FSM, counter, registers, flag logic) is in this module.

Test Plan:
- Add, WIDTH=64:
  - Stimulus: a=64'h00000000_FFFFFFFF, b=1, op_sub=0.
  - Response: after 8 RUN cycles, out_valid with result=64'h00000001_00000000, carry=0, overflow=0, zero=0.
  - Checks carry propagation across 4 slices.
- Subtract equal operands:
  - Stimulus: a=b=64'h1234_5678_9ABC_DEF0, op_sub=1.
  - Response: result=0, zero=1, carry=1 (no borrow), overflow=0.
- Signed overflow and wrap:
  - Stimulus 1: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, add → result=64'h8000_0000_0000_0000, overflow=1, carry=0.
  - Stimulus 2: a=64'hFFFF_FFFF_FFFF_FFFF, b=1 → result=0, carry=1, zero=1, overflow=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
  - Response: result and flags stable; in_ready=0; new request accepted only on the first IDLE cycle after the handshake.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously at RUN counter=3.
  - Response: immediately out_valid=0, busy=0, in_ready=1, result=0. After release, a fresh 3+4 request returns 7.
- Back-to-back throughput:
  - Stimulus: out_ready=1, in_valid held high with 10 random add/sub pairs.
  - Response: each result matches the reference model; the interval between out_valid pulses is 10 cycles.

Source files
------------

// File: rtl/ysyx_220053_cla_seq_ctrl_pkg.sv
// rtl/ysyx_220053_cla_seq_ctrl_pkg.sv - shared state encoding and slice width for the sequential CLA controller
package ysyx_220053_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ysyx_220053_cla_seq_ctrl_cla8.sv
// rtl/ysyx_220053_cla_seq_ctrl_cla8.sv - 8-bit carry-lookahead adder slice built from two 4-bit lookahead groups
module ysyx_220053_CLA8
  import ysyx_220053_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] f,
  output logic               cout
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:0]   c;

  // Each nibble's carries are expanded directly from its carry-in; the
  // upper nibble takes its carry-in from the lower group's generate/propagate.
  always_comb begin
    p = x ^ y;
    g = x & y;
    c = '0;
    c[0] = cin;
    for (int n = 0; n < 2; n++) begin
      c[4*n+1] = g[4*n]   | (p[4*n]   & c[4*n]);
      c[4*n+2] = g[4*n+1] | (p[4*n+1] & g[4*n])
                          | (p[4*n+1] & p[4*n]   & c[4*n]);
      c[4*n+3] = g[4*n+2] | (p[4*n+2] & g[4*n+1])
                          | (p[4*n+2] & p[4*n+1] & g[4*n])
                          | (p[4*n+2] & p[4*n+1] & p[4*n] & c[4*n]);
      c[4*n+4] = g[4*n+3] | (p[4*n+3] & g[4*n+2])
                          | (p[4*n+3] & p[4*n+2] & g[4*n+1])
                          | (p[4*n+3] & p[4*n+2] & p[4*n+1] & g[4*n])
                          | (p[4*n+3] & p[4*n+2] & p[4*n+1] & p[4*n] & c[4*n]);
    end
    f    = p ^ c[SLICE_W-1:0];
    cout = c[SLICE_W];
  end

endmodule

// File: rtl/ysyx_220053_cla_seq_ctrl.sv
// rtl/ysyx_220053_cla_seq_ctrl.sv - byte-serial add/subtract controller time-sharing one CLA8 slice
module ysyx_220053_cla_seq_ctrl
  import ysyx_220053_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               cy;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;

  logic [SLICE_W-1:0] sx;
  logic [SLICE_W-1:0] sy;
  logic [SLICE_W-1:0] sf;
  logic               scout;
  logic [WIDTH-1:0]   res_next;

  ysyx_220053_CLA8 u_cla8 (
    .x    (sx),
    .y    (sy),
    .cin  (cy),
    .f    (sf),
    .cout (scout)
  );

  // Select the current byte of each operand and splice the slice sum into the result.
  always_comb begin
    sx = opa[int'(cnt)*SLICE_W +: SLICE_W];
    sy = opb[int'(cnt)*SLICE_W +: SLICE_W];
    res_next = result;
    res_next[int'(cnt)*SLICE_W +: SLICE_W] = sf;
  end

  // Control FSM with all handshake outputs and flags registered alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cy        <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            opa      <= a;
            opb      <= op_sub ? ~b : b;
            cy       <= op_sub;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          result <= res_next;
          cy     <= scout;
          if (cnt == LAST) begin
            // opb already holds the inverted operand for subtracts, so one rule covers both ops.
            overflow  <= (opa[WIDTH-1] == opb[WIDTH-1]) && (sf[SLICE_W-1] != opa[WIDTH-1]);
            zero      <= (res_next == '0);
            carry     <= scout;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_220053_cla_seq_ctrl.sv
// tb/tb_ysyx_220053_cla_seq_ctrl.sv - directed self-checking bench for the sequential CLA controller
module tb_ysyx_220053_cla_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        busy;

  int compared;
  int mismatched;

  ysyx_220053_cla_seq_ctrl #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for its result with out_ready low, then hand it off.
  task automatic run_op(input logic sub, input logic [63:0] va, input logic [63:0] vb,
                        output logic [63:0] r, output logic c, output logic ov,
                        output logic z, output int lat);
    int guard;
    out_ready = 1'b0;
    op_sub = sub; a = va; b = vb; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    r = result; c = carry; ov = overflow; z = zero;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    tick(); tick();
    compared++;
    if ({in_ready, out_valid, busy, carry, overflow, zero} !== 6'b100000 || result !== 64'd0) begin
      mismatched++;
      $display("FAIL reset: got rdy/vld/busy/c/ov/z=%b result=%h, want 100000 result=0",
               {in_ready, out_valid, busy, carry, overflow, zero}, result);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_carry_chain();
    logic [63:0] r; logic c, ov, z; int lat;
    run_op(1'b0, 64'h00000000_FFFFFFFF, 64'd1, r, c, ov, z, lat);
    compared++;
    if (r !== 64'h00000001_00000000) begin
      mismatched++; $display("FAIL add_chain_result: got %h want %h", r, 64'h00000001_00000000);
    end
    compared++;
    if ({c, ov, z} !== 3'b000) begin
      mismatched++; $display("FAIL add_chain_flags: got c/ov/z=%b want 000", {c, ov, z});
    end
    compared++;
    if (lat !== 8) begin
      mismatched++; $display("FAIL add_chain_latency: got %0d want 8", lat);
    end
  endtask

  task automatic test_sub_equal();
    logic [63:0] r; logic c, ov, z; int lat;
    run_op(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, r, c, ov, z, lat);
    compared++;
    if (r !== 64'd0) begin
      mismatched++; $display("FAIL sub_equal_result: got %h want 0", r);
    end
    compared++;
    if ({c, ov, z} !== 3'b101) begin
      mismatched++; $display("FAIL sub_equal_flags: got c/ov/z=%b want 101", {c, ov, z});
    end
  endtask

  task automatic test_overflow_wrap();
    logic [63:0] r; logic c, ov, z; int lat;
    run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, r, c, ov, z, lat);
    compared++;
    if (r !== 64'h8000_0000_0000_0000 || {c, ov, z} !== 3'b010) begin
      mismatched++;
      $display("FAIL signed_overflow: got %h c/ov/z=%b want 8000000000000000 010", r, {c, ov, z});
    end
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, r, c, ov, z, lat);
    compared++;
    if (r !== 64'd0 || {c, ov, z} !== 3'b101) begin
      mismatched++;
      $display("FAIL unsigned_wrap: got %h c/ov/z=%b want 0 101", r, {c, ov, z});
    end
    run_op(1'b1, 64'h8000_0000_0000_0000, 64'd1, r, c, ov, z, lat);
    compared++;
    if (r !== 64'h7FFF_FFFF_FFFF_FFFF || {c, ov, z} !== 3'b110) begin
      mismatched++;
      $display("FAIL sub_overflow: got %h c/ov/z=%b want 7fffffffffffffff 110", r, {c, ov, z});
    end
    run_op(1'b1, 64'd3, 64'd5, r, c, ov, z, lat);
    compared++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE || {c, ov, z} !== 3'b000) begin
      mismatched++;
      $display("FAIL sub_borrow: got %h c/ov/z=%b want fffffffffffffffe 000", r, {c, ov, z});
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held; int guard;
    out_ready = 1'b0;
    op_sub = 1'b0; a = 64'd5; b = 64'd3; in_valid = 1'b1;
    tick();
    a = 64'd100; b = 64'd1;
    guard = 0;
    while (!out_valid && guard < 50) begin tick(); guard++; end
    held = result;
    compared++;
    if (held !== 64'd8) begin
      mismatched++; $display("FAIL bp_result: got %h want 8", held);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if (result !== 64'd8 || {out_valid, in_ready, busy, carry, overflow, zero} !== 6'b101000) begin
        mismatched++;
        $display("FAIL bp_hold_%0d: got %h vld/rdy/busy/c/ov/z=%b want 8 101000", i, result,
                 {out_valid, in_ready, busy, carry, overflow, zero});
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    compared++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      mismatched++; $display("FAIL bp_idle: got vld/rdy/busy=%b want 010", {out_valid, in_ready, busy});
    end
    tick();
    in_valid = 1'b0;
    compared++;
    if ({in_ready, busy} !== 2'b01) begin
      mismatched++; $display("FAIL bp_accept: got rdy/busy=%b want 01", {in_ready, busy});
    end
    guard = 0;
    while (!out_valid && guard < 50) begin tick(); guard++; end
    compared++;
    if (result !== 64'd101) begin
      mismatched++; $display("FAIL bp_second: got %h want 101", result);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] r; logic c, ov, z; int lat;
    out_ready = 1'b0;
    op_sub = 1'b0; a = 64'hFFFF; b = 64'hFFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({out_valid, busy, in_ready} !== 3'b001 || result !== 64'd0) begin
      mismatched++;
      $display("FAIL reset_mid_run: got vld/busy/rdy=%b result=%h want 001 result=0",
               {out_valid, busy, in_ready}, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(1'b0, 64'd3, 64'd4, r, c, ov, z, lat);
    compared++;
    if (r !== 64'd7 || {c, ov, z} !== 3'b000) begin
      mismatched++; $display("FAIL after_reset_op: got %h c/ov/z=%b want 7 000", r, {c, ov, z});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pa [10];
    logic [63:0] pb [10];
    logic        ps [10];
    logic [64:0] sum;
    logic [63:0] er;
    logic        ec, eov;
    int ii, oi, last_cyc, cyc;
    logic pend;
    for (int i = 0; i < 10; i++) begin
      pa[i] = {$urandom, $urandom};
      pb[i] = {$urandom, $urandom};
      ps[i] = 1'($urandom_range(0, 1));
    end
    pa[3] = 64'h7000_0000_0000_0000; pb[3] = 64'h9000_0000_0000_0000; ps[3] = 1'b1;
    ii = 0; oi = 0; last_cyc = 0; pend = 1'b0;
    out_ready = 1'b1;
    a = pa[0]; b = pb[0]; op_sub = ps[0]; in_valid = 1'b1;
    for (cyc = 0; cyc < 300 && oi < 10; cyc++) begin
      if (pend) begin
        pend = 1'b0;
        ii++;
        if (ii < 10) begin a = pa[ii]; b = pb[ii]; op_sub = ps[ii]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        if (ps[oi]) sum = {1'b0, pa[oi]} + {1'b0, ~pb[oi]} + 65'd1;
        else        sum = {1'b0, pa[oi]} + {1'b0, pb[oi]};
        er = sum[63:0]; ec = sum[64];
        if (ps[oi]) eov = (pa[oi][63] != pb[oi][63]) && (er[63] != pa[oi][63]);
        else        eov = (pa[oi][63] == pb[oi][63]) && (er[63] != pa[oi][63]);
        compared++;
        if (result !== er || {carry, overflow, zero} !== {ec, eov, er == 64'd0}) begin
          mismatched++;
          $display("FAIL b2b_%0d: got %h c/ov/z=%b want %h %b", oi, result,
                   {carry, overflow, zero}, er, {ec, eov, er == 64'd0});
        end
        if (oi > 0) begin
          compared++;
          if (cyc - last_cyc !== 10) begin
            mismatched++; $display("FAIL b2b_interval_%0d: got %0d want 10", oi, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        oi++;
      end
      if (in_ready && in_valid) pend = 1'b1;
      tick();
    end
    compared++;
    if (oi !== 10) begin
      mismatched++; $display("FAIL b2b_count: got %0d results want 10", oi);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_add_carry_chain();
    test_sub_equal();
    test_overflow_wrap();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
